// File: rtl/jtkcpu_alu_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_alu_ctl
//  Purpose  : Sequencer between KCPU microcode and the ALU. Latches one
//             request, launches single- or multi-cycle ALU operations
//             (divider, D/memory shifts), feeds register-shift partial results
//             back, and returns result/CC with a one-cycle done strobe.
//             A watchdog aborts operations whose busy never clears.
//  Revision : 1.0 - initial release
// ============================================================================
module jtkcpu_alu_ctl #(
  parameter int TMO = 24,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           req,
  input  logic [OPW-1:0] op,
  input  logic [15:0]    a,
  input  logic [15:0]    b,
  input  logic [7:0]     cc_in,
  input  logic           idx,
  output logic           ready,
  output logic [OPW-1:0] alu_op,
  output logic [15:0]    alu_opnd0,
  output logic [15:0]    alu_opnd1,
  output logic [7:0]     alu_cc,
  output logic           alu_div_en,
  output logic           alu_shd_en,
  output logic           alu_idx_en,
  input  logic           alu_busy,
  input  logic [15:0]    alu_rslt,
  input  logic [15:0]    alu_rslt_hi,
  input  logic [7:0]     alu_cc_out,
  output logic           done,
  output logic           err,
  output logic [15:0]    rslt,
  output logic [15:0]    rslt_hi,
  output logic [7:0]     cc_out
);

  // Opcodes of the multi-cycle operations (jtkcpu.inc encoding)
  localparam logic [OPW-1:0] OP_DIVXB    = OPW'(8'h6A);
  localparam logic [OPW-1:0] OP_ASRD_IMM = OPW'(8'h70);
  localparam logic [OPW-1:0] OP_ASRD_IDX = OPW'(8'h71);
  localparam logic [OPW-1:0] OP_LSRD_IMM = OPW'(8'h72);
  localparam logic [OPW-1:0] OP_LSRD_IDX = OPW'(8'h73);
  localparam logic [OPW-1:0] OP_ASLD_IMM = OPW'(8'h74);
  localparam logic [OPW-1:0] OP_ASLD_IDX = OPW'(8'h75);
  localparam logic [OPW-1:0] OP_RORD_IMM = OPW'(8'h76);
  localparam logic [OPW-1:0] OP_RORD_IDX = OPW'(8'h77);
  localparam logic [OPW-1:0] OP_ROLD_IMM = OPW'(8'h78);
  localparam logic [OPW-1:0] OP_ROLD_IDX = OPW'(8'h79);

  // Operation classes
  localparam logic [1:0] CLS_SGL = 2'd0;
  localparam logic [1:0] CLS_DIV = 2'd1;
  localparam logic [1:0] CLS_SHR = 2'd2;
  localparam logic [1:0] CLS_SHM = 2'd3;

  localparam int WDW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [OPW-1:0] opr;
  logic [15:0]    r0, r1;
  logic [7:0]     rcc;
  logic           ridx;
  logic [1:0]     cls;
  logic [3:0]     cnt;
  logic           guard;
  logic [WDW-1:0] wdog;

  logic accept, cap_alu, cap_bypass, abort, feed;

  function automatic logic [1:0] decode(input logic [OPW-1:0] o);
    case (o)
      OP_DIVXB:                                   decode = CLS_DIV;
      OP_ASRD_IMM, OP_LSRD_IMM, OP_ASLD_IMM,
      OP_RORD_IMM, OP_ROLD_IMM:                   decode = CLS_SHR;
      OP_ASRD_IDX, OP_LSRD_IDX, OP_ASLD_IDX,
      OP_RORD_IDX, OP_ROLD_IDX:                   decode = CLS_SHM;
      default:                                    decode = CLS_SGL;
    endcase
  endfunction

  // ALU drive: transparent while idle, latched operands once a request is held
  assign ready      = (state == S_IDLE);
  assign done       = (state == S_DONE);
  assign alu_op     = ready ? op    : opr;
  assign alu_opnd0  = ready ? a     : r0;
  assign alu_opnd1  = ready ? b     : r1;
  assign alu_cc     = ready ? cc_in : rcc;
  assign alu_idx_en = ready ? idx   : ridx;
  assign alu_div_en = (state == S_LAUNCH) && (cls == CLS_DIV);
  assign alu_shd_en = (state == S_LAUNCH) && (cls == CLS_SHR || cls == CLS_SHM)
                      && (cnt != 4'd0);

  // State register; cen=0 freezes the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= S_IDLE;
    else if (cen) state <= state_nx;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    cap_alu    = 1'b0;
    cap_bypass = 1'b0;
    abort      = 1'b0;
    feed       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept   = 1'b1;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cls == CLS_SGL) begin
          cap_alu  = 1'b1;
          state_nx = S_DONE;
        end else if (cls != CLS_DIV && cnt == 4'd0) begin
          cap_bypass = 1'b1;
          state_nx   = S_DONE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!guard && !alu_busy) begin
          cap_alu  = 1'b1;
          state_nx = S_DONE;
        end else if (wdog == WDW'(TMO - 1)) begin
          // busy still pending on the last allowed WAIT cycle
          abort    = 1'b1;
          state_nx = S_DONE;
        end else begin
          feed = (cls == CLS_SHR) && alu_busy;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latches, shift feedback, watchdog and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr     <= '0;
      r0      <= '0;
      r1      <= '0;
      rcc     <= '0;
      ridx    <= 1'b0;
      cls     <= CLS_SGL;
      cnt     <= '0;
      guard   <= 1'b0;
      wdog    <= '0;
      err     <= 1'b0;
      rslt    <= '0;
      rslt_hi <= '0;
      cc_out  <= '0;
    end else if (cen) begin
      if (accept) begin
        opr  <= op;
        r0   <= a;
        r1   <= b;
        rcc  <= cc_in;
        ridx <= idx;
        cls  <= decode(op);
        cnt  <= idx ? a[11:8] : b[3:0];
      end
      if (state == S_LAUNCH) begin
        guard <= 1'b1;
        wdog  <= '0;
      end
      if (state == S_WAIT) begin
        guard <= 1'b0;
        wdog  <= wdog + 1'b1;
      end
      if (feed) begin
        r0  <= alu_rslt;
        rcc <= alu_cc_out;
      end
      if (cap_alu) begin
        rslt    <= alu_rslt;
        rslt_hi <= alu_rslt_hi;
        cc_out  <= alu_cc_out;
        err     <= 1'b0;
      end
      if (cap_bypass) begin
        rslt   <= (cls == CLS_SHM) ? r1 : r0;
        cc_out <= rcc;
        err    <= 1'b0;
      end
      if (abort) begin
        cc_out <= rcc;
        err    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
